fb_rect_writer: RTL and testbench

- Upstream pixel-write engine for the double-buffered 160x120x24-bit virtual framebuffer.
- Accepts rectangle-fill commands over a valid/ready handshake and expands each into one framebuffer write per cycle.
- Drives the framebuffer's external write port: external_address, external_data, external_start.
- Address layout is column-major, addr = x*120 + y. Writes stall while the framebuffer is not accepting them.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_rect_writer_if.sv | 29 ++
 rtl/fb_addr_gen.sv | 58 +++++
 rtl/fb_rect_writer.sv | 130 +++++++++++++
 tb/tb_fb_rect_writer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the rectangle-fill framebuffer writer.
// The 160x120 framebuffer is stored column-major: addr = x*VH + y.
package fb_pkg;

  localparam int VW = 160;
  localparam int VH = 120;
  localparam int AW = 15;
  localparam int CW = 24;

  localparam logic [CW-1:0] BLACK = 24'h000000;
  localparam logic [CW-1:0] WHITE = 24'hFFFFFF;

  typedef enum logic [7:0] {
    IDLE  = 8'h00,
    SETUP = 8'h01,
    DRAW  = 8'h02,
    FIN   = 8'h03,
    ERROR = 8'hFF
  } state_t;

  // x*120 + y as shift-and-subtract. The worst case is x=255, y=127, which gives
  // 30727 and still fits AW bits, so nothing overflows.
  function automatic logic [AW-1:0] col_base_of(input logic [7:0] x, input logic [6:0] y);
    logic [AW-1:0] xw;
    xw = AW'(x);
    return (xw << 7) - (xw << 3) + AW'(y);
  endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Command handshake and framebuffer write port for fb_rect_writer.
// The master side is the command source and the framebuffer; the slave side is the writer.
interface fb_rect_writer_if;
  import fb_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_x;
  logic [6:0]    cmd_y;
  logic [7:0]    cmd_w;
  logic [6:0]    cmd_h;
  logic [CW-1:0] cmd_color;

  logic          fb_ready;
  logic [AW-1:0] external_address;
  logic [CW-1:0] external_data;
  logic          external_start;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_ready,
    input  cmd_ready, external_address, external_data, external_start
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_ready,
    output cmd_ready, external_address, external_data, external_start
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Column/row walker for one rectangle. It advances one pixel per unstalled step,
// going down a column first and then rebasing to the next column by +VH.
module fb_addr_gen
  import fb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic          stall,
    input  logic [AW-1:0] base_init,
    input  logic [7:0]    w_eff,
    input  logic [6:0]    h_eff,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [7:0]    col;
    logic [6:0]    row;
    logic [AW-1:0] col_base;
    logic [7:0]    w_q;
    logic [6:0]    h_q;
    logic          row_end;
    logic          col_end;
    logic          advance;

    assign row_end = (row == h_q - 7'd1);
    assign col_end = (col == w_q - 8'd1);
    assign last    = row_end && col_end;
    assign advance = step && !stall && !last;
    assign addr    = col_base + AW'(row);

    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col      <= '0;
            row      <= '0;
            col_base <= '0;
            w_q      <= '0;
            h_q      <= '0;
        end else if (load) begin
            col      <= '0;
            row      <= '0;
            col_base <= base_init;
            w_q      <= w_eff;
            h_q      <= h_eff;
        end else if (advance) begin
            if (row_end) begin
                row      <= '0;
                col      <= col + 8'd1;
                col_base <= col_base + AW'(VH);
            end else begin
                row <= row + 7'd1;
            end
        end
    end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine that turns each command into one framebuffer write per ready cycle.
// Define FB_RECT_CLIP_EN to clip out-of-range rectangles; without it they are rejected and err pulses.
module fb_rect_writer
  import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fb_rect_writer_if.slave    bus,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t        state, state_nxt;
    logic [7:0]    x_q, w_q;
    logic [6:0]    y_q, h_q;
    logic [CW-1:0] color_q;
    logic          err_q;

    logic          cmd_ready_q;
    logic          start_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] data_q;

    logic          accept;
    logic [7:0]    w_room, w_eff;
    logic [6:0]    h_room, h_eff;
    logic          skip_err;
    logic          gen_load;
    logic [AW-1:0] gen_addr;
    logic          gen_last;

    assign accept               = bus.cmd_valid && cmd_ready_q;
    assign bus.cmd_ready        = cmd_ready_q;
    assign bus.external_start   = start_q;
    assign bus.external_address = addr_q;
    assign bus.external_data    = data_q;

    // The clip limits are taken from the latched command, so the SETUP cycle does all of the clipping.
    always_comb begin
        w_room = 8'd0;
        h_room = 7'd0;
        if ({1'b0, x_q} < 9'(VW)) w_room = 8'(9'(VW) - {1'b0, x_q});
        if ({1'b0, y_q} < 8'(VH)) h_room = 7'(8'(VH) - {1'b0, y_q});
        w_eff = (w_q < w_room) ? w_q : w_room;
        h_eff = (h_q < h_room) ? h_q : h_room;
    end

`ifdef FB_RECT_CLIP_EN
    assign skip_err = 1'b0;
`else
    assign skip_err = ({1'b0, x_q} >= 9'(VW)) || ({1'b0, y_q} >= 8'(VH)) ||
                      ({1'b0, x_q} + {1'b0, w_q} > 9'(VW)) ||
                      ({1'b0, y_q} + {1'b0, h_q} > 8'(VH));
`endif

    fb_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (gen_load),
        .step      (state == DRAW),
        .stall     (!bus.fb_ready),
        .base_init (col_base_of(x_q, y_q)),
        .w_eff     (w_eff),
        .h_eff     (h_eff),
        .addr      (gen_addr),
        .last      (gen_last)
    );

    // NOTE: every always_comb output gets a default first so that no path can infer a latch.
    always_comb begin
        state_nxt = state;
        gen_load  = 1'b0;
        unique case (state)
            IDLE:  if (accept) state_nxt = SETUP;
            SETUP: begin
                gen_load  = 1'b1;
                state_nxt = (skip_err || w_eff == 8'd0 || h_eff == 7'd0) ? FIN : DRAW;
            end
            DRAW:  if (bus.fb_ready && gen_last) state_nxt = FIN;
            FIN:   state_nxt = accept ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= BLACK;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            start_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= BLACK;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            start_q     <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= (state_nxt == SETUP) || (state_nxt == DRAW);
            cmd_ready_q <= (state_nxt == IDLE) || (state_nxt == FIN);
            if (accept) begin
                x_q     <= bus.cmd_x;
                y_q     <= bus.cmd_y;
                w_q     <= bus.cmd_w;
                h_q     <= bus.cmd_h;
                color_q <= bus.cmd_color;
            end
            if (state == SETUP) err_q <= skip_err;
            // When a write stalls, only the strobe drops; the address and data keep their last values.
            if (state == DRAW && bus.fb_ready) begin
                start_q <= 1'b1;
                addr_q  <= gen_addr;
                data_q  <= color_q;
            end
            if (state == FIN) begin
                done <= 1'b1;
                err  <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer. Cycle numbers count clock edges after the edge that accepted the command.
// The clipped/rejected corner case follows FB_RECT_CLIP_EN.
module tb_fb_rect_writer;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, done, err;
  int   checks = 0;
  int   errors = 0;

  int            obs_addr[$];
  int            obs_cyc[$];
  logic [CW-1:0] obs_data[$];
  int            done_cyc;
  int            err_cyc;

  fb_rect_writer_if bus ();

  fb_rect_writer dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                       input logic [6:0] h, input logic [CW-1:0] c, output logic ready_pre);
    bus.cmd_valid = 1'b1;
    bus.cmd_x = x; bus.cmd_y = y; bus.cmd_w = w; bus.cmd_h = h; bus.cmd_color = c;
    ready_pre = bus.cmd_ready;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_x = 8'hAA; bus.cmd_y = 7'h55; bus.cmd_w = 8'h33; bus.cmd_h = 7'h22; bus.cmd_color = 24'hDEAD00;
  endtask

  // Watches the outputs edge by edge until done, and holds fb_ready low for edges [stall_from, stall_from+stall_len).
  task automatic collect(input int stall_from, input int stall_len, input int budget);
    obs_addr.delete(); obs_cyc.delete(); obs_data.delete();
    done_cyc = -1; err_cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      bus.fb_ready = !(k >= stall_from && k < stall_from + stall_len);
      tick();
      if (bus.external_start) begin
        obs_addr.push_back(int'(bus.external_address));
        obs_cyc.push_back(k);
        obs_data.push_back(bus.external_data);
      end
      if (err) err_cyc = k;
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    bus.fb_ready = 1'b1;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.fb_ready = 1'b1;
    bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_color = '0;
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    checks++; if (bus.external_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus.external_start); end
    checks++; if (bus.external_address !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.external_address); end
    checks++; if (bus.external_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.external_data); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {busy, done, err}); end
    rst = 1'b1;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_single_pixel();
    logic rdy;
    issue(8'd0, 7'd0, 8'd1, 7'd1, 24'hFF0000, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL single_accept: ready %b want 1", rdy); end
    checks++; if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL single_busy: busy %b ready %b want 1 0", busy, bus.cmd_ready); end
    collect(0, 0, 50);
    checks++; if (obs_addr.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", obs_addr.size()); end
    else begin
      checks++; if (obs_addr[0] !== 0) begin errors++; $display("FAIL single_addr: got %0d want 0", obs_addr[0]); end
      checks++; if (obs_cyc[0] !== 2) begin errors++; $display("FAIL single_strobe_cyc: got %0d want 2", obs_cyc[0]); end
      checks++; if (obs_data[0] !== 24'hFF0000) begin errors++; $display("FAIL single_data: got %h want ff0000", obs_data[0]); end
    end
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL single_done_cyc: got %0d want 3", done_cyc); end
    checks++; if (err_cyc !== -1) begin errors++; $display("FAIL single_err: got cycle %0d want none", err_cyc); end
  endtask

  task automatic run_rect(input string tag, input int stall_from, input int stall_len,
                          input int exp_cyc[6], input int exp_done);
    logic rdy;
    int   exp_addr[6] = '{243, 244, 245, 363, 364, 365};
    issue(8'd2, 7'd3, 8'd2, 7'd3, 24'h00FF00, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s_accept: ready %b want 1", tag, rdy); end
    collect(stall_from, stall_len, 80);
    checks++; if (obs_addr.size() !== 6) begin errors++; $display("FAIL %s_count: got %0d want 6", tag, obs_addr.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (obs_addr[i] !== exp_addr[i] || obs_cyc[i] !== exp_cyc[i] || obs_data[i] !== 24'h00FF00) begin
          errors++;
          $display("FAIL %s_write%0d: got addr %0d cyc %0d data %h want addr %0d cyc %0d data 00ff00",
                   tag, i, obs_addr[i], obs_cyc[i], obs_data[i], exp_addr[i], exp_cyc[i]);
        end
      end
    end
    checks++; if (done_cyc !== exp_done) begin errors++; $display("FAIL %s_done_cyc: got %0d want %0d", tag, done_cyc, exp_done); end
  endtask

  task automatic test_rect();
    run_rect("rect", 0, 0, '{2, 3, 4, 5, 6, 7}, 8);
  endtask

  task automatic test_stall();
    run_rect("stall", 4, 4, '{2, 3, 8, 9, 10, 11}, 12);
  endtask

  task automatic test_corner();
    logic rdy;
    issue(8'd159, 7'd119, 8'd4, 7'd4, WHITE, rdy);
    collect(0, 0, 50);
`ifdef FB_RECT_CLIP_EN
    checks++; if (obs_addr.size() !== 1) begin errors++; $display("FAIL corner_count: got %0d want 1", obs_addr.size()); end
    else begin
      checks++; if (obs_addr[0] !== 19199) begin errors++; $display("FAIL corner_addr: got %0d want 19199", obs_addr[0]); end
    end
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL corner_done_cyc: got %0d want 3", done_cyc); end
    checks++; if (err_cyc !== -1) begin errors++; $display("FAIL corner_err: got cycle %0d want none", err_cyc); end
`else
    checks++; if (obs_addr.size() !== 0) begin errors++; $display("FAIL corner_count: got %0d want 0", obs_addr.size()); end
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL corner_done_cyc: got %0d want 2", done_cyc); end
    checks++; if (err_cyc !== 2) begin errors++; $display("FAIL corner_err_cyc: got %0d want 2", err_cyc); end
`endif
  endtask

  task automatic test_back_to_back();
    logic rdy;
    issue(8'd5, 7'd5, 8'd0, 7'd3, WHITE, rdy);
    tick();
    checks++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_fin: ready %b busy %b want 1 0", bus.cmd_ready, busy); end
    checks++; if (bus.external_start !== 1'b0) begin errors++; $display("FAIL zero_strobe: got %b want 0", bus.external_start); end
    issue(8'd1, 7'd0, 8'd1, 7'd2, 24'h0000FF, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_accept: ready %b want 1", rdy); end
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero_done: done %b busy %b want 1 1", done, busy); end
    collect(0, 0, 50);
    checks++; if (obs_addr.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", obs_addr.size()); end
    else begin
      checks++; if (obs_addr[0] !== 120 || obs_addr[1] !== 121) begin errors++; $display("FAIL b2b_addr: got %0d %0d want 120 121", obs_addr[0], obs_addr[1]); end
      checks++; if (obs_cyc[0] !== 2 || obs_data[1] !== 24'h0000FF) begin errors++; $display("FAIL b2b_first: cyc %0d data %h want 2 0000ff", obs_cyc[0], obs_data[1]); end
    end
    checks++; if (done_cyc !== 4) begin errors++; $display("FAIL b2b_done_cyc: got %0d want 4", done_cyc); end
  endtask

  task automatic test_reset_mid();
    logic rdy;
    int   strobes;
    issue(8'd10, 7'd10, 8'd10, 7'd10, 24'h123456, rdy);
    bus.fb_ready = 1'b1;
    repeat (5) tick();
    checks++; if (bus.external_start !== 1'b1 || bus.external_address !== 15'd1213) begin
      errors++; $display("FAIL mid_drawing: start %b addr %0d want 1 1213", bus.external_start, bus.external_address);
    end
    #3 rst = 1'b0;
    #1;
    checks++; if (bus.external_start !== 1'b0 || bus.external_address !== '0 || bus.external_data !== '0) begin
      errors++; $display("FAIL mid_reset_port: start %b addr %0d data %h want 0 0 0", bus.external_start, bus.external_address, bus.external_data);
    end
    checks++; if ({busy, done, err, bus.cmd_ready} !== 4'b0001) begin errors++; $display("FAIL mid_reset_status: got %b want 0001", {busy, done, err, bus.cmd_ready}); end
    strobes = 0;
    repeat (3) begin tick(); if (bus.external_start) strobes++; end
    rst = 1'b1;
    repeat (5) begin tick(); if (bus.external_start || done) strobes++; end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL mid_no_writes: got %0d events want 0", strobes); end
    checks++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_idle: ready %b busy %b want 1 0", bus.cmd_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_rect();
    test_stall();
    test_corner();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
